// File: rtl/kds_pkg.sv
// Shared types and constants for the kernel data shifter (KDS) bank and its loader.
// No ports: a package.
//   loader_state_t : loader FSM states
//   triplet_t      : one {v_1, v_2, v_3} data triplet
package kds_pkg;

  localparam int KDS_NB_LANES      = 12;
  localparam int KDS_LANE_DEPTH    = 8;
  localparam int KDS_IO_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  typedef struct packed {
    logic [KDS_IO_DATA_WIDTH-1:0] w1;
    logic [KDS_IO_DATA_WIDTH-1:0] w2;
    logic [KDS_IO_DATA_WIDTH-1:0] w3;
  } triplet_t;

endpackage

// File: rtl/kds_triplet_buf.sv
// One-lane staging buffer: DEPTH entries of triplet_t, one write port and one
// asynchronous read port. Data is not reset.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write slot
//   wr_data  : triplet to store
//   rd_addr  : read slot
//   rd_data  : triplet stored at rd_addr
module kds_triplet_buf
  import kds_pkg::*;
#(
  parameter int DEPTH = KDS_LANE_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  triplet_t      wr_data,
  input  logic [AW-1:0] rd_addr,
  output triplet_t      rd_data
);

  triplet_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/kds_loader.sv
// Producer for the KDS bank. Collects one lane's worth of triplets from an
// upstream valid/ready stream, then bursts them into that lane with its
// LE_select bit held for LANE_DEPTH back-to-back cycles, lanes 0..NB_LANES-1.
// Ports:
//   clk, arst_n_in        : clock, async active-low reset
//   start                 : pulse in IDLE begins a full load
//   din_1..3, din_valid   : upstream triplet stream
//   din_ready             : high in FILL
//   v_1..3, LE_select     : registered drive to the KDS
//   busy                  : high in FILL or BURST
//   load_done             : one-cycle pulse (the DONE cycle)
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting triplets into the lane buffer
// BURST | streaming the buffer into lane lane_cnt, one triplet per cycle
// DONE  | single cycle, load_done high
//
// IO_DATA_WIDTH must equal KDS_IO_DATA_WIDTH since triplet_t is fixed-width.
module kds_loader
  import kds_pkg::*;
#(
  parameter int IO_DATA_WIDTH = KDS_IO_DATA_WIDTH,
  parameter int NB_LANES      = KDS_NB_LANES,
  parameter int LANE_DEPTH    = KDS_LANE_DEPTH
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  input  logic [IO_DATA_WIDTH-1:0] din_1,
  input  logic [IO_DATA_WIDTH-1:0] din_2,
  input  logic [IO_DATA_WIDTH-1:0] din_3,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [IO_DATA_WIDTH-1:0] v_1,
  output logic [IO_DATA_WIDTH-1:0] v_2,
  output logic [IO_DATA_WIDTH-1:0] v_3,
  output logic [NB_LANES-1:0]      LE_select,
  output logic                     busy,
  output logic                     load_done
);

  localparam int SW = $clog2(LANE_DEPTH);
  localparam int LW = $clog2(NB_LANES);

  loader_state_t     state;
  logic [LW-1:0]     lane_cnt;
  logic [SW-1:0]     slot_cnt;
  logic              xfer;
  logic              last_slot;
  logic              last_lane;
  logic [NB_LANES-1:0] lane_onehot;
  triplet_t          wr_data;
  triplet_t          rd_data;

  assign din_ready   = (state == FILL);
  assign busy        = (state == FILL) || (state == BURST);
  assign xfer        = din_valid && din_ready;
  assign last_slot   = (slot_cnt == SW'(LANE_DEPTH - 1));
  assign last_lane   = (lane_cnt == LW'(NB_LANES - 1));
  assign lane_onehot = {{(NB_LANES-1){1'b0}}, 1'b1} << lane_cnt;
  assign wr_data     = {din_1, din_2, din_3};

  kds_triplet_buf #(
    .DEPTH (LANE_DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (xfer),
    .wr_addr (slot_cnt),
    .wr_data (wr_data),
    .rd_addr (slot_cnt),
    .rd_data (rd_data)
  );

  // slot_cnt is log2(LANE_DEPTH) wide, so incrementing past the last slot
  // returns it to 0 without an explicit clear.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      slot_cnt  <= '0;
      v_1       <= '0;
      v_2       <= '0;
      v_3       <= '0;
      LE_select <= '0;
      load_done <= 1'b0;
    end else begin
      LE_select <= '0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            lane_cnt <= '0;
            slot_cnt <= '0;
          end
        end
        FILL: begin
          if (xfer) begin
            slot_cnt <= slot_cnt + SW'(1);
            if (last_slot) state <= BURST;
          end
        end
        BURST: begin
          v_1       <= rd_data.w1;
          v_2       <= rd_data.w2;
          v_3       <= rd_data.w3;
          LE_select <= lane_onehot;
          slot_cnt  <= slot_cnt + SW'(1);
          if (last_slot) begin
            if (last_lane) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              lane_cnt <= lane_cnt + LW'(1);
              state    <= FILL;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kds_loader.sv
`timescale 1ns/1ps
module tb_kds_loader;
  import kds_pkg::*;

  localparam int W  = 16;
  localparam int NL = 12;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  din_1 = '0, din_2 = '0, din_3 = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [W-1:0]  v_1, v_2, v_3;
  logic [NL-1:0] LE_select;
  logic          busy, load_done;

  kds_loader #(.IO_DATA_WIDTH(W), .NB_LANES(NL), .LANE_DEPTH(D)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .din_valid(din_valid), .din_ready(din_ready),
    .v_1(v_1), .v_2(v_2), .v_3(v_3),
    .LE_select(LE_select), .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: every accepted triplet, in acceptance order, must appear
  // on v_* in lane acc_index/D, with lanes streamed in order.
  typedef struct {
    int          lane;
    logic [W-1:0] a, b, c;
  } exp_t;

  exp_t           exp_q[$];
  logic [3*W-1:0] ref_mem [NL][D];
  logic [3*W-1:0] kds_mem [NL][D];
  int             kds_wp  [NL];

  int acc_cnt = 0;
  bit drive_en = 0, rand_valid = 0, rand_data = 0, stall_en = 0;
  int stall_cnt = 0;
  bit stall_chk = 0;
  bit accepted = 0;
  exp_t drv_e;

  // Driver
  initial begin
    forever begin
      @(negedge clk);
      if (stall_chk) begin
        check("stall_le_select", LE_select, 0);
        stall_chk = 0;
      end
      accepted = 0;
      if (arst_n_in && din_valid && din_ready) begin
        drv_e.lane = acc_cnt / D;
        drv_e.a = din_1; drv_e.b = din_2; drv_e.c = din_3;
        exp_q.push_back(drv_e);
        if (drv_e.lane < NL) ref_mem[drv_e.lane][acc_cnt % D] = {din_1, din_2, din_3};
        acc_cnt++;
        accepted = 1;
        if (stall_en && acc_cnt == 4*D + 3) stall_cnt = 5;
      end
      @(posedge clk);
      #1;
      if (accepted || !din_valid) begin
        if (rand_data) begin
          din_1 = W'($urandom); din_2 = W'($urandom); din_3 = W'($urandom);
        end else begin
          din_1 = W'(3*acc_cnt); din_2 = W'(3*acc_cnt + 1); din_3 = W'(3*acc_cnt + 2);
        end
      end
      if (stall_cnt > 0) begin
        din_valid = 1'b0;
        stall_cnt--;
        stall_chk = 1;
      end else if (!drive_en) begin
        din_valid = 1'b0;
      end else begin
        din_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor
  int run = 0, bursts = 0, done_cnt = 0, done_cyc = 0;
  exp_t mon_e;
  logic [NL-1:0] mon_oh;
  initial begin
    forever begin
      @(negedge clk);
      if (!arst_n_in) begin
        run = 0;
      end else begin
        if (load_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (LE_select != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_burst_word", LE_select, 0);
          end else begin
            mon_e = exp_q.pop_front();
            mon_oh = '0;
            mon_oh[mon_e.lane] = 1'b1;
            check("le_select", LE_select, mon_oh);
            check("v_1", v_1, mon_e.a);
            check("v_2", v_2, mon_e.b);
            check("v_3", v_3, mon_e.c);
          end
          for (int i = 0; i < NL; i++) begin
            if (LE_select[i]) begin
              kds_mem[i][kds_wp[i]] = {v_1, v_2, v_3};
              kds_wp[i] = (kds_wp[i] + 1) % D;
            end
          end
          run++;
        end else if (run != 0) begin
          check("burst_length", run, D);
          bursts++;
          run = 0;
        end
      end
    end
  end

  task automatic run_load(input bit rv, input bit rd, input bit st, input bit mid_start,
                          input bit chk_lat);
    int s_cyc, d0, b0, t;
    bit mid_done;
    mid_done = 0;
    exp_q.delete();
    acc_cnt = 0;
    rand_valid = rv; rand_data = rd; stall_en = st; drive_en = 1;
    for (int i = 0; i < NL; i++) kds_wp[i] = 0;
    d0 = done_cnt; b0 = bursts;
    @(posedge clk); #1;
    start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
      if (mid_start && !mid_done && LE_select == NL'(12'h004)) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mid_done = 1;
      end
    end
    check("load_finished_in_time", (t < 5000), 1);
    if (chk_lat) check("load_latency", done_cyc - s_cyc, NL*2*D + 1);
    if (mid_start) check("mid_start_issued", mid_done, 1);
    drive_en = 0;
    repeat (20) @(posedge clk);
    #1;
    check("bursts_per_load", bursts - b0, NL);
    check("load_done_pulses", done_cnt - d0, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_after_load", busy, 0);
    check("le_select_after_load", LE_select, 0);
  endtask

  initial begin
    int t, hits;
    for (int i = 0; i < NL; i++) kds_wp[i] = 0;

    // Reset and idle
    arst_n_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_le_select", LE_select, 0);
    check("reset_din_ready", din_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_load_done", load_done, 0);
    check("reset_v_1", v_1, 0);
    arst_n_in = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_le_select", LE_select, 0);
      check("idle_din_ready", din_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_load_done", load_done, 0);
    end

    // Full load with deterministic data, no stalls: latency checked
    run_load(0, 0, 0, 0, 1);

    // Random data and valid, 5-cycle stall in lane 4, start during lane 2 burst
    run_load(1, 1, 1, 1, 0);

    // Reset in the middle of lane 5's burst
    rand_valid = 0; rand_data = 0; stall_en = 0; drive_en = 1;
    exp_q.delete(); acc_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0; hits = 0;
    while (hits < 3 && t < 2000) begin
      @(negedge clk);
      t++;
      if (LE_select == NL'(12'h020)) hits++;
    end
    check("reached_lane5_burst", (t < 2000), 1);
    #2 arst_n_in = 1'b0;
    drive_en = 0;
    #1;
    check("async_reset_le_select", LE_select, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_din_ready", din_ready, 0);
    exp_q.delete(); acc_cnt = 0;
    repeat (2) @(posedge clk);
    #3 arst_n_in = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_idle_le", LE_select, 0);

    // Fresh load after reset, random traffic, then end-to-end KDS contents
    run_load(1, 1, 0, 0, 0);
    for (int i = 0; i < NL; i++) begin
      for (int s = 0; s < D; s++) begin
        check($sformatf("kds_lane%0d_slot%0d", i, s), kds_mem[i][s], ref_mem[i][s]);
      end
      check($sformatf("kds_lane%0d_wrap", i), kds_wp[i], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
